// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with forwarding and ALU operand select
//
// Captures the decoded ID instruction on each rising edge, resolves rs/rt
// against the EX/MEM and MEM/WB forwarding buses, and drives the ALU inputs.
// Optional feature macro: LOAD_USE_DETECT_EN (load-use detection and
// automatic bubble insertion; when undefined load_use is tied to 0).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_*                  decoded instruction from ID (valid, data, imm,
//                         shamt, register numbers, ALU code, control bits)
//   stall, flush          hold / bubble controls from the hazard unit
//   exmem_*, memwb_*      forwarding sources (regwrite, rd, value)
//   ex_valid              EX slot holds a real instruction
//   alu_in1, alu_in2      ALU operands after forwarding and source select
//   alu_ctl, alu_sign     ALU operation code and signed-compare flag
//   ex_store_data         forwarded rt value for stores
//   ex_rd                 destination register
//   ex_regwrite/memread/memwrite  control bits gated by ex_valid
//   load_use              ID/IF must hold this cycle
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [CTL_W-1:0]  id_aluctl,
    input  logic              id_sign,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_regwrite,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_value,
    input  logic              memwb_regwrite,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_value,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CTL_W-1:0]  alu_ctl,
    output logic              alu_sign,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              load_use
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [CTL_W-1:0]  aluctl;
        logic              sign;
        logic              alusrc1;
        logic              alusrc2;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } slot_t;

    slot_t q;
    slot_t id_slot;

    assign id_slot = '{
        valid:    id_valid,
        rs_data:  id_rs_data,
        rt_data:  id_rt_data,
        imm:      id_imm,
        shamt:    id_shamt,
        rs:       id_rs,
        rt:       id_rt,
        rd:       id_rd,
        aluctl:   id_aluctl,
        sign:     id_sign,
        alusrc1:  id_alusrc1,
        alusrc2:  id_alusrc2,
        regwrite: id_regwrite,
        memread:  id_memread,
        memwrite: id_memwrite
    };

    // An all-zero slot is the bubble: invalid, AND opcode, zero operands.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= '0;
        end else if (stall) begin
            q <= q;
`ifdef LOAD_USE_DETECT_EN
        end else if (load_use) begin
            q <= '0;
`endif
        end else begin
            q <= id_slot;
        end
    end

    // Nearest producer wins; $0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd(input logic [4:0] src,
                                              input logic [DATA_W-1:0] reg_data);
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src))
            return exmem_value;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src))
            return memwb_value;
        else
            return reg_data;
    endfunction

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign fwd_rs        = fwd(q.rs, q.rs_data);
    assign fwd_rt        = fwd(q.rt, q.rt_data);

    assign ex_valid      = q.valid;
    assign alu_in1       = q.alusrc1 ? {{(DATA_W-5){1'b0}}, q.shamt} : fwd_rs;
    assign alu_in2       = q.alusrc2 ? q.imm : fwd_rt;
    assign alu_ctl       = q.aluctl;
    assign alu_sign      = q.sign;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = q.rd;
    assign ex_regwrite   = q.regwrite & q.valid;
    assign ex_memread    = q.memread  & q.valid;
    assign ex_memwrite   = q.memwrite & q.valid;

`ifdef LOAD_USE_DETECT_EN
    // id_rt is compared even when the ID instruction does not read rt.
    assign load_use = ex_memread & (q.rd != 5'd0) & id_valid &
                      ((id_rs == q.rd) | (id_rt == q.rd));
`else
    assign load_use = 1'b0;
`endif

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-select stage of the 5-stage CPU. It captures a decoded instruction at the clock edge, forwards results from EX/MEM and MEM/WB, and drives the ALU inputs `in1`, `in2`, `ALUCtl` and `Sign`. It also detects load-use hazards and inserts bubbles, and it honours the stall and flush controls from the hazard/branch unit.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width; only 32 is supported.
- `CTL_W`, default 5: ALU control width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID slot holds a real instruction.
- `id_rs_data`, `id_rt_data`  in  32  register-file read data.
- `id_imm`  in  32  immediate, already sign- or zero-extended.
- `id_shamt`  in  5  shift amount.
- `id_rs`, `id_rt`, `id_rd`  in  5  source and destination register numbers.
- `id_aluctl`  in  5  ALU operation code.
- `id_sign`  in  1  signed compare.
- `id_alusrc1`  in  1  1 = shamt drives `alu_in1`.
- `id_alusrc2`  in  1  1 = immediate drives `alu_in2`.
- `id_regwrite`, `id_memread`, `id_memwrite`  in  1  control bits.
- `stall`  in  1  hold stage contents.
- `flush`  in  1  replace the captured instruction with a bubble.
- `exmem_regwrite`  in  1, `exmem_rd`  in  5, `exmem_value`  in  32: EX/MEM forwarding source.
- `memwb_regwrite`  in  1, `memwb_rd`  in  5, `memwb_value`  in  32: MEM/WB forwarding source.
- `ex_valid`  out  1  EX slot valid.
- `alu_in1`, `alu_in2`  out  32  ALU operands.
- `alu_ctl`  out  5  ALU operation code.
- `alu_sign`  out  1  signed compare, to the ALU.
- `ex_store_data`  out  32  forwarded rt value, for stores.
- `ex_rd`  out  5  destination register.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`  out  1  gated control bits.
- `load_use`  out  1  hazard request; ID/IF must hold.

## Operation
- Registered fields: valid, rs/rt data, imm, shamt, rs, rt, rd, aluctl, sign, alusrc1/2, regwrite, memread, memwrite.
- Update priority each edge: reset > flush > stall > load_use > load.
  - reset: all fields cleared to 0.
  - flush: all fields cleared to 0, which is a bubble.
  - stall: hold every field.
  - load_use: bubble.
  - otherwise: load the ID inputs.
- Forwarding is combinational, from the registered fields and the current forwarding buses, applied to rs and rt independently:
  - First, EX/MEM if `exmem_regwrite` && `exmem_rd` != 0 && `exmem_rd` == src.
  - Else MEM/WB if `memwb_regwrite` && `memwb_rd` != 0 && `memwb_rd` == src.
  - Else the registered data.
- Operand selection:
  - `alu_in1` = alusrc1 ? {27'b0, shamt} : fwd_rs. Shift operations place shamt in `in1[4:0]` and rt in `in2`.
  - `alu_in2` = alusrc2 ? imm : fwd_rt.
  - `ex_store_data` = fwd_rt, always.
- Output gating: `ex_regwrite`, `ex_memread` and `ex_memwrite` are each ANDed with `ex_valid`.
  - `alu_ctl` and `alu_sign` pass through unchanged.
  - A bubble therefore presents ALU code 5'b00000 (AND) with zero operands.
- Load-use detection: `load_use` = `ex_valid` & `ex_memread` & (`ex_rd` != 0) & `id_valid` & (`id_rs` == `ex_rd` | `id_rt` == `ex_rd`).
  - `id_rt` is compared regardless of how the instruction uses rt; this is conservative.

## Timing
- Latency: 1 cycle from the ID inputs to the registered fields.
- Outputs are valid in the same cycle as the forwarding buses, with no extra cycle.
- `load_use` is combinational. Behaviour while it is high:
  - Upstream holds the ID instruction that cycle.
  - This stage loads a bubble.
  - The next cycle the load is in MEM, `load_use` drops, and the held instruction loads and forwards from MEM/WB a cycle later.
- `stall` together with `load_use`: stall wins and contents hold. `load_use` stays asserted while the conditions hold.
- `flush` together with `stall`: flush wins, giving a bubble.
- Reset mid-stream: the next cycle `ex_valid` = 0 and all outputs are 0.
- Reset values: `ex_valid`, `alu_in1`, `alu_in2`, `alu_ctl`, `alu_sign`, `ex_store_data`, `ex_rd`, all control outputs and `load_use` are 0.
  - This holds provided the forwarding buses are idle, since the outputs are combinational over them.
- Register `$0` is never forwarded, even when `regwrite` is asserted.

## Configuration
- `LOAD_USE_DETECT_EN` defined: load-use detection and automatic bubble insertion as described above.
- Not defined:
  - `load_use` is tied to 0 and the load_use priority level is removed.
  - Software must schedule a delay slot after loads.
  - Forwarding and stall/flush behaviour are unchanged.

## Test plan
- **Reset and bubble.** Assert `reset` with random inputs, then deassert with `id_valid` = 0 → all outputs 0, `alu_ctl` = 5'b00000.
- **Basic load.** Load `id_rs_data` = 0x5, `id_rt_data` = 0x7, `id_aluctl` = 5'b00010, no forwarding → the next cycle `alu_in1` = 5, `alu_in2` = 7, `alu_ctl` = 5'b00010, `ex_valid` = 1.
- **Forwarding priority.**
  - rs = 3, with EX/MEM writing r3 = 0xAAAA and MEM/WB writing r3 = 0xBBBB → `alu_in1` = 0xAAAA.
  - Drop EX/MEM → `alu_in1` = 0xBBBB.
  - rd = 0 on either source → the registered data is used.
- **Shift and immediate selection.**
  - alusrc1 = 1, shamt = 4, rt = 0x80000000, with MEM/WB writing rt = 0x10 → `alu_in1` = 4, `alu_in2` = 0x10.
  - alusrc2 = 1, imm = 0xFFFFFFFC → `alu_in2` = 0xFFFFFFFC while `ex_store_data` stays forwarded.
- **Load-use.** An lw to r8 in EX while ID has rs = 8 → `load_use` = 1 and the next cycle `ex_valid` = 0.
  - The cycle after that, the dependent instruction is valid and takes r8 from MEM/WB.
  - Without `LOAD_USE_DETECT_EN`: `load_use` = 0 and the instruction loads immediately.
- **Stall vs flush.**
  - `stall` held for 3 cycles while ID changes → outputs are unchanged.
  - `stall` and `flush` together → a bubble.
  - `stall` and `load_use` together → contents hold.
